// File: rtl/dso_capture_ctrl.sv
// Capture controller for the DSO sample RAM: pre-trigger fill, wait for trigger, post-trigger fill.
// Optional auto-trigger timeout is built only when DSO_AUTO_TRIG_EN is defined.
module dso_capture_ctrl #(
  parameter int DEPTH        = 512,
  parameter int AW           = 9,
  parameter int AUTO_SAMPLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_start,
  input  logic          done_clr,
  input  logic          sample_en,
  input  logic [AW-1:0] trig_pos,
  input  logic          triggered,
  output logic          trig_en,
  output logic          armed,
  output logic          set_capture_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trace_end,
  output logic          capturing,
  output logic          done,
  output logic          timed_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] tpos_q, tpos_d;
  logic [AW:0]   fill_cnt_q, fill_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] trace_end_q, trace_end_d;
  logic          armed_q, armed_d;
  logic          trig_en_q, trig_en_d;
  logic          capturing_q, capturing_d;
  logic          done_q, done_d;
  logic          set_done_q, set_done_d;
  logic          timed_out_d;
  logic          auto_fire;
  logic [AW:0]   arm_thresh;
  logic          we_int;

  assign we_int     = sample_en & capturing_q;
  assign arm_thresh = DEPTH_W - {1'b0, tpos_q};

`ifdef DSO_AUTO_TRIG_EN
  localparam int ACW = $clog2(AUTO_SAMPLES + 1);

  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
  logic           auto_fire_q, auto_fire_d;
  logic           timed_out_q;

  // Count armed samples in WAIT; the hit is registered so the forced trigger lands a cycle later
  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_fire_d = 1'b0;
    if (state_q == S_IDLE && capture_start) begin
      auto_cnt_d = '0;
    end else if (state_q == S_WAIT && armed_q && sample_en && !auto_fire_q) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
      if (auto_cnt_d == ACW'(AUTO_SAMPLES)) begin
        auto_fire_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt_q  <= '0;
      auto_fire_q <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_fire_q <= auto_fire_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign auto_fire = auto_fire_q;
  assign timed_out = timed_out_q;
`else
  assign auto_fire = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tpos_d      = tpos_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    waddr_d     = waddr_q;
    armed_d     = armed_q;
    trace_end_d = trace_end_q;
`ifdef DSO_AUTO_TRIG_EN
    timed_out_d = timed_out_q;
`else
    timed_out_d = 1'b0;
`endif

    if (we_int) begin
      waddr_d = waddr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (capture_start) begin
          tpos_d      = trig_pos;
          fill_cnt_d  = '0;
          post_cnt_d  = '0;
          armed_d     = 1'b0;
          timed_out_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (we_int && fill_cnt_q != DEPTH_W) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
        // Arm off the next count so armed appears right after the qualifying write
        if (fill_cnt_d >= arm_thresh) begin
          armed_d = 1'b1;
        end
        if (armed_q && (triggered || auto_fire)) begin
          state_d = (tpos_q == '0) ? S_DONE : S_POST;
          if (auto_fire && !triggered) begin
            timed_out_d = 1'b1;
          end
        end
      end
      S_POST: begin
        if (we_int) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == tpos_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (done_clr) begin
          armed_d     = 1'b0;
          timed_out_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    set_done_d = (state_d == S_DONE) && (state_q != S_DONE);
    if (set_done_d) begin
      trace_end_d = waddr_d - 1'b1;
    end

    trig_en_d   = (state_d == S_WAIT);
    capturing_d = (state_d == S_WAIT) || (state_d == S_POST);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tpos_q      <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      waddr_q     <= '0;
      trace_end_q <= '0;
      armed_q     <= 1'b0;
      trig_en_q   <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
      set_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tpos_q      <= tpos_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      waddr_q     <= waddr_d;
      trace_end_q <= trace_end_d;
      armed_q     <= armed_d;
      trig_en_q   <= trig_en_d;
      capturing_q <= capturing_d;
      done_q      <= done_d;
      set_done_q  <= set_done_d;
    end
  end

  assign trig_en          = trig_en_q;
  assign armed            = armed_q;
  assign set_capture_done = set_done_q;
  assign we               = we_int;
  assign waddr            = waddr_q;
  assign trace_end        = trace_end_q;
  assign capturing        = capturing_q;
  assign done             = done_q;

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed testbench for dso_capture_ctrl with hand-computed expectations.
module tb_dso_capture_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture_start;
  logic          done_clr;
  logic          sample_en;
  logic [AW-1:0] trig_pos;
  logic          triggered;
  logic          trig_en;
  logic          armed;
  logic          set_capture_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trace_end;
  logic          capturing;
  logic          done;
  logic          timed_out;

  int checks = 0;
  int errors = 0;

  dso_capture_ctrl #(.DEPTH(512), .AW(AW), .AUTO_SAMPLES(16)) dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .done_clr(done_clr),
    .sample_en(sample_en), .trig_pos(trig_pos), .triggered(triggered),
    .trig_en(trig_en), .armed(armed), .set_capture_done(set_capture_done),
    .we(we), .waddr(waddr), .trace_end(trace_end), .capturing(capturing),
    .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_capture(input logic [AW-1:0] tp);
    trig_pos = tp;
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_start = 1'b0; done_clr = 1'b0; sample_en = 1'b0;
    trig_pos = '0; triggered = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({trig_en, armed, set_capture_done, we, capturing, done, timed_out} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000000",
               {trig_en, armed, set_capture_done, we, capturing, done, timed_out});
    end
    checks++;
    if (waddr !== 9'd0 || trace_end !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr got waddr=%0d trace_end=%0d want 0 0", waddr, trace_end);
    end
  endtask

  task automatic test_pretrig_100();
    start_capture(9'd100);
    checks++;
    if (trig_en !== 1'b1 || capturing !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_start got trig_en=%b capturing=%b armed=%b want 1 1 0", trig_en, capturing, armed);
    end
    sample_en = 1'b1;
    for (int n = 1; n <= 599; n++) begin
      tick();
      if (n == 411) begin
        checks++;
        if (armed !== 1'b0) begin
          errors++; $display("[TB] FAIL t1_armed_411 got %b want 0", armed);
        end
      end
      if (n == 412) begin
        checks++;
        if (armed !== 1'b1) begin
          errors++; $display("[TB] FAIL t1_armed_412 got %b want 1", armed);
        end
      end
    end
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    checks++;
    if (trig_en !== 1'b0 || capturing !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_post got trig_en=%b capturing=%b done=%b want 0 1 0", trig_en, capturing, done);
    end
    for (int k = 1; k <= 100; k++) begin
      if (k == 100) begin
        checks++;
        if (we !== 1'b1 || set_capture_done !== 1'b0) begin
          errors++; $display("[TB] FAIL t1_last_post got we=%b scd=%b want 1 0", we, set_capture_done);
        end
      end
      tick();
    end
    checks++;
    if (set_capture_done !== 1'b1 || done !== 1'b1 || capturing !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_done got scd=%b done=%b capturing=%b we=%b want 1 1 0 0",
               set_capture_done, done, capturing, we);
    end
    checks++;
    if (trace_end !== 9'd187) begin
      errors++; $display("[TB] FAIL t1_trace_end got %0d want 187", trace_end);
    end
    tick();
    checks++;
    if (set_capture_done !== 1'b0 || done !== 1'b1 || armed !== 1'b1 || waddr !== 9'd188) begin
      errors++;
      $display("[TB] FAIL t1_hold got scd=%b done=%b armed=%b waddr=%0d want 0 1 1 188",
               set_capture_done, done, armed, waddr);
    end
    sample_en = 1'b0;
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    checks++;
    if (done !== 1'b0 || armed !== 1'b0 || trig_en !== 1'b0) begin
      errors++; $display("[TB] FAIL t1_clr got done=%b armed=%b trig_en=%b want 0 0 0", done, armed, trig_en);
    end
  endtask

  task automatic test_tpos_zero();
    start_capture(9'd0);
    sample_en = 1'b1;
    do_writes(511);
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("[TB] FAIL t2_armed_511 got %b want 0", armed);
    end
    tick();
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("[TB] FAIL t2_armed_512 got %b want 1", armed);
    end
    sample_en = 1'b0;
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    checks++;
    if (done !== 1'b1 || set_capture_done !== 1'b1 || trace_end !== 9'd187 || waddr !== 9'd188) begin
      errors++;
      $display("[TB] FAIL t2_done got done=%b scd=%b trace_end=%0d waddr=%0d want 1 1 187 188",
               done, set_capture_done, trace_end, waddr);
    end
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
  endtask

  task automatic test_early_trigger();
    start_capture(9'd500);
    sample_en = 1'b1;
    do_writes(5);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    checks++;
    if (trig_en !== 1'b1 || capturing !== 1'b1 || armed !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t3_early got trig_en=%b capturing=%b armed=%b done=%b want 1 1 0 0",
               trig_en, capturing, armed, done);
    end
    do_writes(5);
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("[TB] FAIL t3_armed_11 got %b want 0", armed);
    end
    tick();
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("[TB] FAIL t3_armed_12 got %b want 1", armed);
    end
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    checks++;
    if (trig_en !== 1'b0 || capturing !== 1'b1) begin
      errors++; $display("[TB] FAIL t3_post got trig_en=%b capturing=%b want 0 1", trig_en, capturing);
    end
    do_writes(499);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL t3_early_done got %b want 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || set_capture_done !== 1'b1 || trace_end !== 9'd188 || waddr !== 9'd189) begin
      errors++;
      $display("[TB] FAIL t3_done got done=%b scd=%b trace_end=%0d waddr=%0d want 1 1 188 189",
               done, set_capture_done, trace_end, waddr);
    end
    sample_en = 1'b0;
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
  endtask

  task automatic test_rst_in_post();
    start_capture(9'd100);
    sample_en = 1'b1;
    do_writes(412);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    do_writes(3);
    checks++;
    if (capturing !== 1'b1 || trig_en !== 1'b0) begin
      errors++; $display("[TB] FAIL t4_in_post got capturing=%b trig_en=%b want 1 0", capturing, trig_en);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({trig_en, armed, set_capture_done, we, capturing, done, timed_out} !== 7'b0 ||
        waddr !== 9'd0 || trace_end !== 9'd0) begin
      errors++;
      $display("[TB] FAIL t4_rst got flags=%b waddr=%0d trace_end=%0d want 0000000 0 0",
               {trig_en, armed, set_capture_done, we, capturing, done, timed_out}, waddr, trace_end);
    end
    rst = 1'b0;
    sample_en = 1'b0;
    tick();
    checks++;
    if (set_capture_done !== 1'b0 || done !== 1'b0 || trig_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t4_after got scd=%b done=%b trig_en=%b want 0 0 0", set_capture_done, done, trig_en);
    end
  endtask

  task automatic test_ignored_and_wrap();
    start_capture(9'd4);
    sample_en = 1'b1;
    do_writes(10);
    trig_pos = 9'd7;
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    checks++;
    if (capturing !== 1'b1 || trig_en !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t5_start_in_wait got capturing=%b trig_en=%b done=%b want 1 1 0", capturing, trig_en, done);
    end
    do_writes(496);
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_armed_507 got %b want 0", armed);
    end
    tick();
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("[TB] FAIL t5_armed_508 got %b want 1", armed);
    end
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    tick();
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    checks++;
    if (capturing !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_clr_in_post got capturing=%b done=%b want 1 0", capturing, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_post3 got done=%b want 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || set_capture_done !== 1'b1 || trace_end !== 9'd0 || waddr !== 9'd1) begin
      errors++;
      $display("[TB] FAIL t5_done got done=%b scd=%b trace_end=%0d waddr=%0d want 1 1 0 1",
               done, set_capture_done, trace_end, waddr);
    end
    sample_en = 1'b0;
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    checks++;
    if (done !== 1'b0 || capturing !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_idle got done=%b capturing=%b want 0 0", done, capturing);
    end
    start_capture(9'd0);
    checks++;
    if (waddr !== 9'd1 || trig_en !== 1'b1) begin
      errors++; $display("[TB] FAIL t5_second_start got waddr=%0d trig_en=%b want 1 1", waddr, trig_en);
    end
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    checks++;
    if (waddr !== 9'd2) begin
      errors++; $display("[TB] FAIL t5_second_write got waddr=%0d want 2", waddr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

`ifdef DSO_AUTO_TRIG_EN
  task automatic test_auto_trigger();
    start_capture(9'd2);
    sample_en = 1'b1;
    do_writes(510);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("[TB] FAIL t6_armed got %b want 1", armed);
    end
    do_writes(16);
    tick();
    checks++;
    if (capturing !== 1'b1 || trig_en !== 1'b0 || timed_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_post got capturing=%b trig_en=%b timed_out=%b want 1 0 1", capturing, trig_en, timed_out);
    end
    do_writes(2);
    checks++;
    if (done !== 1'b1 || timed_out !== 1'b1) begin
      errors++; $display("[TB] FAIL t6_done got done=%b timed_out=%b want 1 1", done, timed_out);
    end
    sample_en = 1'b0;
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    checks++;
    if (timed_out !== 1'b0) begin
      errors++; $display("[TB] FAIL t6_clr got timed_out=%b want 0", timed_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pretrig_100();
    test_tpos_zero();
    test_early_trigger();
    test_rst_in_post();
    test_ignored_and_wrap();
`ifdef DSO_AUTO_TRIG_EN
    test_auto_trigger();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
